// File: rtl/key_loader32_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_loader_pkg : shared types for the serial key loader      rev 1.0
// ---------------------------------------------------------------------------
package key_loader_pkg;

  localparam int KEY_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } kl_state_e;

endpackage
`default_nettype wire

// File: rtl/key_loader32.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_loader32 : LSB-first serial key loader with even-parity commit  rev 1.0
// ---------------------------------------------------------------------------
module key_loader32
  import key_loader_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int CNT_W = $clog2(KEY_W + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_start_i,
  input  logic             zeroize_i,
  input  logic             key_bit_i,
  input  logic             key_valid_i,
  output logic [KEY_W-1:0] keyinput_o,
  output logic             key_ready_o,
  output logic             busy_o,
  output logic             error_o
);

  kl_state_e        r_state;
  kl_state_e        w_next_state;
  logic [KEY_W-1:0] r_staging;
  logic [CNT_W-1:0] r_cnt;
  logic             r_par;
  logic [KEY_W-1:0] r_key;
  logic             r_ready;
  logic             r_busy;
  logic             r_error;
  logic             w_last_bit;
  logic             w_par_ok;

  assign w_last_bit = (r_cnt == CNT_W'(KEY_W - 1));
  assign w_par_ok   = ~(r_par ^ key_bit_i);

  always_comb begin
    w_next_state = r_state;
    if (zeroize_i) begin
      w_next_state = IDLE;
    end else if (load_start_i) begin
      w_next_state = SHIFT;
    end else begin
      case (r_state)
        SHIFT:   if (key_valid_i && w_last_bit) w_next_state = PARITY;
        PARITY:  if (key_valid_i) w_next_state = w_par_ok ? DONE : ERROR;
        default: w_next_state = r_state;
      endcase
    end
  end

  // Shifting right places the first (LSB) bit at index 0 after KEY_W shifts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_staging <= '0;
      r_cnt     <= '0;
      r_par     <= 1'b0;
      r_key     <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == SHIFT) || (w_next_state == PARITY);
      if (zeroize_i || load_start_i) begin
        r_staging <= '0;
        r_cnt     <= '0;
        r_par     <= 1'b0;
        r_key     <= '0;
        r_ready   <= 1'b0;
        r_error   <= 1'b0;
      end else begin
        case (r_state)
          SHIFT: begin
            if (key_valid_i) begin
              r_staging <= {key_bit_i, r_staging[KEY_W-1:1]};
              r_par     <= r_par ^ key_bit_i;
              r_cnt     <= r_cnt + CNT_W'(1);
            end
          end
          PARITY: begin
            if (key_valid_i) begin
              if (w_par_ok) begin
                r_key   <= r_staging;
                r_ready <= 1'b1;
              end else begin
                r_error <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign keyinput_o  = r_key;
  assign key_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign error_o     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_key_loader32.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_key_loader32 : directed self-checking bench for key_loader32   rev 1.0
// ---------------------------------------------------------------------------
module tb_key_loader32;

  logic        clk;
  logic        rst_ni;
  logic        load_start;
  logic        zeroize;
  logic        key_bit;
  logic        key_valid;
  logic [31:0] keyinput;
  logic        key_ready;
  logic        busy;
  logic        error;

  int tests;
  int fails;

  key_loader32 dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .load_start_i (load_start),
    .zeroize_i    (zeroize),
    .key_bit_i    (key_bit),
    .key_valid_i  (key_valid),
    .keyinput_o   (keyinput),
    .key_ready_o  (key_ready),
    .busy_o       (busy),
    .error_o      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic b);
    key_valid = 1'b1;
    key_bit   = b;
    tick();
    key_valid = 1'b0;
    key_bit   = 1'b0;
  endtask

  // Sends n LSBs of w; with gaps, a hole cycle precedes every third bit.
  task automatic send_word(input logic [31:0] w, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 2)) begin
        key_valid = 1'b0;
        tick();
        check("busy_in_hole", {31'd0, busy}, 32'd1);
      end
      send(w[i]);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst_ni     = 1'b0;
    load_start = 1'b0;
    zeroize    = 1'b0;
    key_bit    = 1'b0;
    key_valid  = 1'b0;

    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    check("rst_key",   keyinput,            32'h0);
    check("rst_ready", {31'd0, key_ready},  32'd0);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_error", {31'd0, error},      32'd0);

    // Good contiguous frame
    start();
    check("good_busy_start", {31'd0, busy}, 32'd1);
    send_word(32'hA5A50F3C, 32, 1'b0);
    check("good_ready_before_par", {31'd0, key_ready}, 32'd0);
    check("good_key_before_par",   keyinput,           32'h0);
    check("good_busy_in_par",      {31'd0, busy},      32'd1);
    send(1'b0);
    check("good_ready", {31'd0, key_ready}, 32'd1);
    check("good_key",   keyinput,           32'hA5A50F3C);
    check("good_busy",  {31'd0, busy},      32'd0);
    check("good_error", {31'd0, error},     32'd0);
    send(1'b1);
    send(1'b1);
    check("done_ignores_key", keyinput, 32'hA5A50F3C);

    // Gapped frame
    start();
    check("start_clears_key",   keyinput,           32'h0);
    check("start_clears_ready", {31'd0, key_ready}, 32'd0);
    send_word(32'hA5A50F3C, 32, 1'b1);
    key_valid = 1'b0;
    tick();
    check("gap_busy_pre_par", {31'd0, busy}, 32'd1);
    send(1'b0);
    check("gap_ready", {31'd0, key_ready}, 32'd1);
    check("gap_key",   keyinput,           32'hA5A50F3C);
    check("gap_busy",  {31'd0, busy},      32'd0);

    // Bad parity
    start();
    send_word(32'hA5A50F3C, 32, 1'b0);
    send(1'b1);
    check("bad_error", {31'd0, error},     32'd1);
    check("bad_ready", {31'd0, key_ready}, 32'd0);
    check("bad_key",   keyinput,           32'h0);
    check("bad_busy",  {31'd0, busy},      32'd0);
    send(1'b0);
    check("bad_error_sticky", {31'd0, error}, 32'd1);
    start();
    check("start_clears_error", {31'd0, error}, 32'd0);

    // Zeroize over a committed key, mid second frame
    send_word(32'hA5A50F3C, 32, 1'b0);
    send(1'b0);
    check("zz_committed", keyinput, 32'hA5A50F3C);
    start();
    send_word(32'h0003FFFF, 18, 1'b0);
    check("zz_busy_mid", {31'd0, busy}, 32'd1);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check("zz_key",   keyinput,           32'h0);
    check("zz_ready", {31'd0, key_ready}, 32'd0);
    check("zz_busy",  {31'd0, busy},      32'd0);
    check("zz_error", {31'd0, error},     32'd0);
    zeroize    = 1'b1;
    load_start = 1'b1;
    tick();
    zeroize    = 1'b0;
    load_start = 1'b0;
    check("zz_over_start", {31'd0, busy}, 32'd0);

    // Restart after 20 bits; valid during the restart pulse is ignored
    start();
    send_word(32'hFFFFFFFF, 20, 1'b0);
    load_start = 1'b1;
    key_valid  = 1'b1;
    key_bit    = 1'b1;
    tick();
    load_start = 1'b0;
    key_valid  = 1'b0;
    key_bit    = 1'b0;
    send_word(32'h00000001, 32, 1'b0);
    send(1'b1);
    check("restart_ready", {31'd0, key_ready}, 32'd1);
    check("restart_key",   keyinput,           32'h00000001);
    check("restart_error", {31'd0, error},     32'd0);

    // Asynchronous reset drops a committed key between edges
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_key",   keyinput,           32'h0);
    check("async_ready", {31'd0, key_ready}, 32'd0);
    #10;
    rst_ni = 1'b1;
    tick();

    // Asynchronous reset mid-frame drops busy
    start();
    send_word(32'h000003FF, 10, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_busy", {31'd0, busy}, 32'd0);
    #10;
    rst_ni = 1'b1;
    tick();
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
